// File: rtl/arcade_ce_pkg.sv
// Shared types and helpers for the arcade clock-enable / reset sequencer.
package arcade_ce_pkg;

    typedef enum logic [1:0] {
        WAIT_ROM = 2'd0,
        HOLD     = 2'd1,
        RUN      = 2'd2
    } rst_state_e;

    localparam int DEFAULT_DIV_W = 8;

    function automatic int hold_cnt_w(input int hold_cycles);
        return $clog2(hold_cycles + 1);
    endfunction

endpackage

// File: rtl/arcade_ce_div.sv
// One clock-enable divider channel: pulse every D+1 cycles, freezable by pause.
// Optional realign input compiled in when CE_SYNC_EN is defined.
module arcade_ce_div
    import arcade_ce_pkg::*;
#(
    parameter int DIV_W = DEFAULT_DIV_W
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] div_i,
    input  logic             pause_i,
`ifdef CE_SYNC_EN
    input  logic             sync_i,
`endif
    output logic             ce_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             ce_q, ce_d;
    logic             sync_active;

`ifdef CE_SYNC_EN
    assign sync_active = sync_i;
`else
    assign sync_active = 1'b0;
`endif

    // ">=" rather than "==" so a divisor lowered below the running count wraps at once.
    always_comb begin
        cnt_d = cnt_q;
        ce_d  = 1'b0;
        if (sync_active) begin
            cnt_d = '0;
        end else if (pause_i) begin
            cnt_d = cnt_q;
        end else if (cnt_q >= div_i) begin
            cnt_d = '0;
            ce_d  = 1'b1;
        end else begin
            cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            cnt_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ce_q  <= ce_d;
        end
    end

    assign ce_o = ce_q;

endmodule

// File: rtl/arcade_ce_reset.sv
// Clock-enable bank plus core reset sequencer (ROM download, OSD, button sources).
// Defining CE_SYNC_EN adds the ce_sync realign input to every divider.
module arcade_ce_reset
    import arcade_ce_pkg::*;
#(
    parameter int NUM_CE      = 3,
    parameter int DIV_W       = DEFAULT_DIV_W,
    parameter int HOLD_CYCLES = 16,
    parameter int INDEX_W     = 8,
    parameter int ROM_INDEX   = 0
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic [NUM_CE*DIV_W-1:0] ce_div,
    input  logic                    ce_pause,
`ifdef CE_SYNC_EN
    input  logic                    ce_sync,
`endif
    output logic [NUM_CE-1:0]       ce_out,
    input  logic                    ioctl_downl,
    input  logic [INDEX_W-1:0]      ioctl_index,
    input  logic                    status_reset,
    input  logic                    button_reset,
    output logic                    core_reset,
    output logic                    rom_loaded
);

    localparam int                 HCW       = hold_cnt_w(HOLD_CYCLES);
    localparam logic [HCW-1:0]     HOLD_LOAD = HCW'(HOLD_CYCLES);
    localparam logic [INDEX_W-1:0] ROM_IDX   = INDEX_W'(ROM_INDEX);

    for (genvar i = 0; i < NUM_CE; i++) begin : g_ce
        arcade_ce_div #(.DIV_W(DIV_W)) u_div (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .div_i   (ce_div[i*DIV_W +: DIV_W]),
            .pause_i (ce_pause),
`ifdef CE_SYNC_EN
            .sync_i  (ce_sync),
`endif
            .ce_o    (ce_out[i])
        );
    end

    logic               downl_q;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic               rom_loaded_q, rom_loaded_d;
    rst_state_e         state_q, state_d;
    logic [HCW-1:0]     hold_q, hold_d;
    logic               core_reset_q;
    logic               dl_rise, dl_fall, src;

    assign dl_rise      = ioctl_downl & ~downl_q;
    assign dl_fall      = ~ioctl_downl & downl_q;
    assign idx_d        = dl_rise ? ioctl_index : idx_q;
    assign rom_loaded_d = rom_loaded_q | (dl_fall & (idx_q == ROM_IDX));
    assign src          = status_reset | button_reset | ioctl_downl;

    // Leaving WAIT_ROM follows the ROM-loaded flag as it is being set, so the
    // hold window starts on the same edge rom_loaded rises.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            WAIT_ROM: begin
                if (rom_loaded_d) begin
                    state_d = HOLD;
                    hold_d  = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (src) begin
                    hold_d = HOLD_LOAD;
                end else if (hold_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - {{(HCW-1){1'b0}}, 1'b1};
                end
            end
            RUN: begin
                if (src) begin
                    state_d = HOLD;
                    hold_d  = HOLD_LOAD;
                end
            end
            default: state_d = WAIT_ROM;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            downl_q      <= 1'b0;
            idx_q        <= '0;
            rom_loaded_q <= 1'b0;
            state_q      <= WAIT_ROM;
            hold_q       <= '0;
            core_reset_q <= 1'b1;
        end else begin
            downl_q      <= ioctl_downl;
            idx_q        <= idx_d;
            rom_loaded_q <= rom_loaded_d;
            state_q      <= state_d;
            hold_q       <= hold_d;
            core_reset_q <= (state_d != RUN);
        end
    end

    assign core_reset = core_reset_q;
    assign rom_loaded = rom_loaded_q;

endmodule

// File: tb/tb_arcade_ce_reset.sv
// Directed self-checking bench for arcade_ce_reset (default parameters).
module tb_arcade_ce_reset;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [23:0] ce_div;
    logic        ce_pause;
    logic        ce_sync;
    logic [2:0]  ce_out;
    logic        ioctl_downl;
    logic [7:0]  ioctl_index;
    logic        status_reset;
    logic        button_reset;
    logic        core_reset;
    logic        rom_loaded;

    int n_checks = 0;
    int n_errors = 0;

    arcade_ce_reset dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ce_div       (ce_div),
        .ce_pause     (ce_pause),
`ifdef CE_SYNC_EN
        .ce_sync      (ce_sync),
`endif
        .ce_out       (ce_out),
        .ioctl_downl  (ioctl_downl),
        .ioctl_index  (ioctl_index),
        .status_reset (status_reset),
        .button_reset (button_reset),
        .core_reset   (core_reset),
        .rom_loaded   (rom_loaded)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int first [3];
        int cnt   [3];
        int hi;
        int fall_at;

        reset_n      = 1'b0;
        ce_div       = {8'd12, 8'd5, 8'd3};
        ce_pause     = 1'b0;
        ce_sync      = 1'b0;
        ioctl_downl  = 1'b0;
        ioctl_index  = 8'd0;
        status_reset = 1'b0;
        button_reset = 1'b0;
        tick();
        tick();
        check("rst_ce_out", ce_out, 0);
        check("rst_core_reset", core_reset, 1);
        check("rst_rom_loaded", rom_loaded, 0);

        // Dividers D=3/5/12 over 156 edges
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin first[c] = -1; cnt[c] = 0; end
        for (int e = 1; e <= 156; e++) begin
            tick();
            for (int c = 0; c < 3; c++) begin
                if (ce_out[c]) begin
                    cnt[c]++;
                    if (first[c] < 0) first[c] = e;
                end
            end
        end
        check("div3_count", cnt[0], 39);
        check("div5_count", cnt[1], 26);
        check("div12_count", cnt[2], 12);
        check("div3_first", first[0], 4);
        check("div5_first", first[1], 6);
        check("div12_first", first[2], 13);
        check("reset_held_while_dividing", core_reset, 1);

        // Pause with every counter at 2, then resume from the frozen value
        tick();
        tick();
        ce_pause = 1'b1;
        hi = 0;
        for (int e = 0; e < 10; e++) begin
            tick();
            hi += $countones(ce_out);
        end
        check("pause_no_pulses", hi, 0);
        ce_pause = 1'b0;
        for (int c = 0; c < 3; c++) first[c] = -1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            for (int c = 0; c < 3; c++)
                if (ce_out[c] && first[c] < 0) first[c] = e;
        end
        check("resume_ch0_first", first[0], 2);
        check("resume_ch1_first", first[1], 4);
        check("resume_ch2_first", first[2], 11);

        // D=0 on channel 0: enable held high
        ce_div = {8'd12, 8'd5, 8'd0};
        hi = 0;
        for (int e = 0; e < 8; e++) begin
            tick();
            hi += int'(ce_out[0]);
        end
        check("div0_constant_high", hi, 8);

        // Non-ROM download (index 1) must not release reset
        ioctl_index = 8'd1;
        ioctl_downl = 1'b1;
        repeat (20) tick();
        ioctl_downl = 1'b0;
        ioctl_index = 8'd0;
        repeat (30) tick();
        check("idx1_rom_loaded", rom_loaded, 0);
        check("idx1_core_reset", core_reset, 1);

        // ROM download (index 0), index changes when the download ends
        ioctl_index = 8'd0;
        ioctl_downl = 1'b1;
        repeat (20) tick();
        check("dl_rom_loaded_before", rom_loaded, 0);
        ioctl_downl = 1'b0;
        ioctl_index = 8'd3;
        tick();
        check("dl_rom_loaded_one_edge", rom_loaded, 1);
        check("dl_core_reset_edge1", core_reset, 1);
        fall_at = -1;
        for (int e = 2; e <= 40; e++) begin
            tick();
            if (!core_reset && fall_at < 0) fall_at = e;
        end
        check("dl_release_edge", fall_at, 18);

        // One-cycle button pulse in RUN
        button_reset = 1'b1;
        tick();
        button_reset = 1'b0;
        check("btn_rise_one_edge", core_reset, 1);
        hi = 1;
        for (int e = 0; e < 40; e++) begin
            tick();
            hi += int'(core_reset);
        end
        check("btn_high_cycles", hi, 17);

        // Second pulse five edges into HOLD reloads the counter
        button_reset = 1'b1;
        tick();
        button_reset = 1'b0;
        hi = 1;
        for (int e = 0; e < 4; e++) begin
            tick();
            hi += int'(core_reset);
        end
        button_reset = 1'b1;
        tick();
        hi += int'(core_reset);
        button_reset = 1'b0;
        for (int e = 0; e < 40; e++) begin
            tick();
            hi += int'(core_reset);
        end
        check("btn_reload_high_cycles", hi, 22);

        // OSD reset held five cycles
        status_reset = 1'b1;
        hi = 0;
        for (int e = 0; e < 5; e++) begin
            tick();
            hi += int'(core_reset);
        end
        status_reset = 1'b0;
        for (int e = 0; e < 40; e++) begin
            tick();
            hi += int'(core_reset);
        end
        check("osd_high_cycles", hi, 21);

        // reset_n pulsed during a ROM download; the later falling edge still counts
        ioctl_index = 8'd0;
        ioctl_downl = 1'b1;
        repeat (5) tick();
        reset_n = 1'b0;
        repeat (3) tick();
        check("midrst_rom_loaded", rom_loaded, 0);
        check("midrst_core_reset", core_reset, 1);
        check("midrst_ce_out", ce_out, 0);
        reset_n = 1'b1;
        repeat (5) tick();
        check("midrst_rom_loaded_during_dl", rom_loaded, 0);
        ioctl_downl = 1'b0;
        tick();
        check("midrst_rom_loaded_after_dl", rom_loaded, 1);

`ifdef CE_SYNC_EN
        // Realign equal-divisor channels mid-period
        ce_div = {8'd4, 8'd4, 8'd4};
        repeat (7) tick();
        ce_sync = 1'b1;
        tick();
        check("sync_ce_low_1", ce_out, 0);
        tick();
        tick();
        check("sync_ce_low_3", ce_out, 0);
        ce_sync = 1'b0;
        for (int c = 0; c < 3; c++) first[c] = -1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            for (int c = 0; c < 3; c++)
                if (ce_out[c] && first[c] < 0) first[c] = e;
        end
        check("sync_ch0_first", first[0], 5);
        check("sync_ch1_first", first[1], 5);
        check("sync_ch2_first", first[2], 5);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
